// File: rtl/int_ctrl.sv
// int_ctrl: bus-mapped interrupt controller driving the CPU HWInt[5:0] input.
// Define INTC_SYNC_EN for a two-flop input synchroniser; otherwise one input register.
module int_ctrl #(
   parameter int unsigned N_SRC = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [31:0]      Addr,
   input  logic             WE,
   input  logic [31:0]      Din,
   output logic [31:0]      Dout,
   output logic [5:0]       HWInt
);

   typedef enum logic [1:0] {
      REG_PEND = 2'd0,
      REG_MASK = 2'd1,
      REG_MODE = 2'd2,
      REG_RAW  = 2'd3
   } reg_sel_t;

   reg_sel_t         sel;
   logic [N_SRC-1:0] sync_s;
   logic [N_SRC-1:0] prev_s;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] pend_next;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] mode;
   logic [N_SRC-1:0] clr;
   logic             unused_bits;

   assign sel         = reg_sel_t'(Addr[3:2]);
   assign unused_bits = ^{Addr[31:4], Addr[1:0], Din[31:N_SRC]};

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] sync_1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= '0;
         sync_s <= '0;
      end else begin
         sync_1 <= irq_in;
         sync_s <= sync_1;
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         sync_s <= '0;
      else
         sync_s <= irq_in;
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prev_s <= '0;
      else
         prev_s <= sync_s;
   end

   assign rise = sync_s & ~prev_s;
   assign clr  = (WE && sel == REG_PEND) ? Din[N_SRC-1:0] : '0;

   // Edge bits: a rise in the same cycle as a W1C keeps the bit set.
   always_comb begin
      pend_next = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (mode[i])
            pend_next[i] = sync_s[i];
         else
            pend_next[i] = rise[i] | (pend[i] & ~clr[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend <= '0;
         mask <= '0;
         mode <= '0;
      end else begin
         pend <= pend_next;
         if (WE && sel == REG_MASK)
            mask <= Din[N_SRC-1:0];
         if (WE && sel == REG_MODE)
            mode <= Din[N_SRC-1:0];
      end
   end

   always_comb begin
      Dout = '0;
      case (sel)
         REG_PEND: Dout[N_SRC-1:0] = pend;
         REG_MASK: Dout[N_SRC-1:0] = mask;
         REG_MODE: Dout[N_SRC-1:0] = mode;
         REG_RAW:  Dout[N_SRC-1:0] = sync_s;
         default:  Dout = '0;
      endcase
   end

   always_comb begin
      HWInt = '0;
      HWInt[N_SRC-1:0] = pend & mask;
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        reset;
   logic [5:0]  irq_in;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic [5:0]  HWInt;

   int n_chk;
   int n_pass;
   logic [31:0] rd;

   int_ctrl #(.N_SRC(6)) dut (
      .clk    (clk),
      .reset  (reset),
      .irq_in (irq_in),
      .Addr   (Addr),
      .WE     (WE),
      .Din    (Din),
      .Dout   (Dout),
      .HWInt  (HWInt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      Addr = a;
      Din  = d;
      WE   = 1'b1;
      @(negedge clk);
      WE   = 1'b0;
      Din  = '0;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = Dout;
   endtask

   task automatic pulse(input logic [5:0] bits);
      irq_in = bits;
      tick(1);
      irq_in = '0;
      tick(LAT - 1);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      reset  = 1'b0;
      irq_in = '0;
      Addr   = '0;
      WE     = 1'b0;
      Din    = '0;
      tick(3);
      reset = 1'b1;
      tick(2);

      // 1: idle after reset, masked pending
      check("t1_hwint", {26'd0, HWInt}, 32'h0);
      for (int a = 0; a < 16; a += 4) begin
         bus_rd(32'(a), rd);
         check("t1_read0", rd, 32'h0);
      end
      pulse(6'h01);
      bus_rd(32'h0, rd);
      check("t1_pend", rd, 32'h1);
      check("t1_masked", {26'd0, HWInt}, 32'h0);
      tick(1);

      // 2: edge mode pulse on bit1, hold, W1C
      bus_wr(32'h0, 32'h1);
      bus_rd(32'h0, rd);
      check("t2_pend_clr0", rd, 32'h0);
      bus_wr(32'h4, 32'h7);
      bus_wr(32'h8, 32'h0);
      bus_rd(32'h4, rd);
      check("t2_mask_rd", rd, 32'h7);
      irq_in = 6'h02;
      tick(1);
      irq_in = '0;
      tick(LAT - 2);
      check("t2_not_early", {26'd0, HWInt}, 32'h0);
      tick(1);
      check("t2_hwint", {26'd0, HWInt}, 32'h2);
      tick(3);
      check("t2_hold", {26'd0, HWInt}, 32'h2);
      bus_wr(32'h0, 32'h2);
      check("t2_w1c", {26'd0, HWInt}, 32'h0);

      // 3: rise coincides with W1C of bit0
      pulse(6'h01);
      tick(1);
      check("t3_pre", {26'd0, HWInt}, 32'h1);
      irq_in = 6'h01;
      tick(LAT - 1);
      bus_wr(32'h0, 32'h1);
      bus_rd(32'h0, rd);
      check("t3_set_wins", rd, 32'h1);
      bus_wr(32'h0, 32'h1);
      bus_rd(32'h0, rd);
      check("t3_w1c_alone", rd, 32'h0);
      irq_in = '0;
      tick(LAT + 1);

      // 4: level mode on bit2
      bus_wr(32'h8, 32'h4);
      bus_wr(32'h4, 32'h4);
      irq_in = 6'h04;
      tick(LAT - 1);
      check("t4_not_early", {26'd0, HWInt}, 32'h0);
      tick(1);
      check("t4_level_on", {26'd0, HWInt}, 32'h4);
      bus_wr(32'h0, 32'h4);
      bus_rd(32'h0, rd);
      check("t4_w1c_ignored", rd, 32'h4);
      bus_rd(32'hC, rd);
      check("t4_raw", rd, 32'h4);
      tick(10 - LAT - 1);
      irq_in = '0;
      tick(LAT - 1);
      check("t4_still_on", {26'd0, HWInt}, 32'h4);
      tick(1);
      check("t4_level_off", {26'd0, HWInt}, 32'h0);

      // 5: masking never loses a pending bit
      bus_wr(32'h4, 32'h0);
      pulse(6'h01);
      bus_rd(32'h0, rd);
      check("t5_pend", rd, 32'h1);
      check("t5_masked", {26'd0, HWInt}, 32'h0);
      bus_wr(32'h4, 32'h1);
      check("t5_unmask", {26'd0, HWInt}, 32'h1);
      bus_wr(32'h4, 32'h0);
      check("t5_remask", {26'd0, HWInt}, 32'h0);
      bus_rd(32'h0, rd);
      check("t5_pend_kept", rd, 32'h1);

      // 6: asynchronous reset mid-operation, source held through release
      pulse(6'h02);
      bus_wr(32'h4, 32'h3);
      check("t6_pre", {26'd0, HWInt}, 32'h3);
      Addr   = 32'h0;
      irq_in = 6'h01;
      #1;
      reset = 1'b0;
      #1;
      check("t6_hwint_async", {26'd0, HWInt}, 32'h0);
      check("t6_dout_async", Dout, 32'h0);
      tick(2);
      for (int a = 0; a < 16; a += 4) begin
         bus_rd(32'(a), rd);
         check("t6_read0", rd, 32'h0);
      end
      tick(1);
      reset = 1'b1;
      tick(LAT - 1);
      bus_rd(32'h0, rd);
      check("t6_not_early", rd, 32'h0);
      tick(1);
      bus_rd(32'h0, rd);
      check("t6_edge_after_rel", rd, 32'h1);
      bus_wr(32'h0, 32'h1);
      tick(4);
      bus_rd(32'h0, rd);
      check("t6_set_once", rd, 32'h0);
      irq_in = '0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
